// File: rtl/fp_to_int_seq.sv
// fp_to_int_seq: multi-cycle IEEE-754 single to int32 converter, K-bit-per-cycle denormalising shifter.
// Define ROUND_NEAREST_EN for round-half-even; otherwise truncates toward zero.
module fp_to_int_seq #(
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_inexact
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;
  state_t state;
  logic        sgn, left, g, st;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic [7:0]  ex;
  logic [22:0] frac;
  logic        nan, sat, min_int, zero, special, sp_ovf, sp_inx, rnd, g_n, st_n;
  logic [31:0] sp_data, mag_n, mag_r, res;
  logic [4:0]  step;
`ifdef ROUND_NEAREST_EN
  localparam logic [7:0] E_MIN = 8'd126;
  assign rnd = g & (st | mag[0]);
`else
  localparam logic [7:0] E_MIN = 8'd127;
  assign rnd = 1'b0;
`endif
  assign ex       = in_data[30:23];
  assign frac     = in_data[22:0];
  assign in_ready = rst_n & (state == IDLE);
  always_comb begin
    nan     = (ex == 8'd255) && (frac != 23'd0);
    sat     = ex >= 8'd158;
    min_int = in_data[31] && (ex == 8'd158) && (frac == 23'd0);
    zero    = ex < E_MIN;
    special = sat | zero;
    sp_data = zero ? 32'd0 : (in_data[31] && !nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    sp_ovf  = sat && !min_int;
    sp_inx  = zero && ((ex != 8'd0) || (frac != 23'd0));
  end
  assign step = (cnt > 5'(SHIFT_PER_CYCLE)) ? 5'(SHIFT_PER_CYCLE) : cnt;
  // Bits leaving on a right shift: the last becomes guard, earlier guards fold into sticky.
  always_comb begin
    mag_n = mag;
    g_n   = g;
    st_n  = st;
    for (int i = 0; i < SHIFT_PER_CYCLE; i++)
      if (5'(i) < step) begin
        if (left) mag_n = mag_n << 1;
        else begin
          st_n  = st_n | g_n;
          g_n   = mag_n[0];
          mag_n = mag_n >> 1;
        end
      end
  end
  assign mag_r = mag + 32'(rnd);
  assign res   = sgn ? -mag_r : mag_r;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn  <= in_data[31];
          left <= ex > 8'd150;
          cnt  <= (ex > 8'd150) ? 5'(ex - 8'd150) : 5'(8'd150 - ex);
          mag  <= {8'd0, 1'b1, frac};
          g    <= 1'b0;
          st   <= 1'b0;
          if (special) begin
            out_data    <= sp_data;
            out_ovf     <= sp_ovf;
            out_inexact <= sp_inx;
            state       <= DONE;
          end else state <= SHIFT;
        end
        SHIFT: if (cnt == 5'd0) state <= FIX;
        else begin
          mag <= mag_n;
          g   <= g_n;
          st  <= st_n;
          cnt <= cnt - step;
        end
        FIX: begin
          out_data    <= res;
          out_ovf     <= 1'b0;
          out_inexact <= g | st;
          state       <= DONE;
        end
        DONE: if (!out_valid) out_valid <= 1'b1;
        else if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_int_seq.sv
// tb_fp_to_int_seq: directed and randomized checks of fp_to_int_seq against an exact-arithmetic model.
module tb_fp_to_int_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, out_valid, out_ovf, out_inexact;
  logic [31:0] out_data;
  int total = 0, bad = 0;

  fp_to_int_seq #(.SHIFT_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  // Exact value m*2^(E-150), then truncate or round-half-even using the discarded remainder.
  function automatic void ref_model(input logic [31:0] x, output logic [31:0] d,
                                    output logic ovf, output logic inx);
    int e8, r;
    longint unsigned m, q, rem, half;
    e8 = int'(x[30:23]);
    m = 64'(x[22:0]) | (64'd1 << 23);
    d = 0; ovf = 0; inx = 0;
    if (e8 == 255) begin
      ovf = 1;
      d = (x[22:0] != 0) ? 32'h7FFF_FFFF : (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else if (e8 == 0) inx = x[22:0] != 0;
    else if (e8 >= 158) begin
      d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      ovf = !(x[31] && e8 == 158 && x[22:0] == 0);
    end else begin
      if (e8 >= 150) begin
        q = m << (e8 - 150); rem = 0; half = 1;
      end else begin
        r = 150 - e8;
        if (r >= 40) begin q = 0; rem = 1; half = 64'd1 << 39; end
        else begin q = m >> r; rem = m & ((64'd1 << r) - 1); half = 64'd1 << (r - 1); end
      end
      inx = rem != 0;
`ifdef ROUND_NEAREST_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
      d = q[31:0];
      if (x[31]) d = -d;
    end
  endfunction

  task automatic run(input logic [31:0] x, input int hold, output logic [31:0] d,
                     output logic ovf, output logic inx, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1; in_data = x;
    @(posedge clk); #1;
    in_valid = 0; in_data = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    d = out_data; ovf = out_ovf; inx = out_inexact;
    repeat (hold) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if ({out_ovf, out_inexact} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {out_ovf, out_inexact}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
    @(negedge clk); rst_n = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_high got=%b want=1", in_ready); end
  endtask

  localparam int NV = 13;
  localparam logic [31:0] XV [NV] = '{32'h3F80_0000, 32'hC2F6_E979, 32'h4F00_0000, 32'hCF00_0000,
    32'h7FC0_0000, 32'h3FC0_0000, 32'h4020_0000, 32'h3F40_0000, 32'h0000_0001, 32'hFF80_0000,
    32'h4EFF_FFFF, 32'h3F00_0000, 32'h0000_0000};
  localparam logic [31:0] DT [NV] = '{32'd1, 32'hFFFF_FF85, 32'h7FFF_FFFF, 32'h8000_0000,
    32'h7FFF_FFFF, 32'd1, 32'd2, 32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FF80, 32'd0, 32'd0};
  localparam logic [31:0] DR [NV] = '{32'd1, 32'hFFFF_FF85, 32'h7FFF_FFFF, 32'h8000_0000,
    32'h7FFF_FFFF, 32'd2, 32'd2, 32'd1, 32'd0, 32'h8000_0000, 32'h7FFF_FF80, 32'd0, 32'd0};
  localparam logic [1:0] FV [NV] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01,
    2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
  localparam int LT [NV] = '{9, 8, 1, 1, 1, 9, 9, 1, 1, 1, 5, 1, 1};
  localparam int LR [NV] = '{9, 8, 1, 1, 1, 9, 9, 9, 1, 1, 5, 9, 1};

  task automatic test_directed();
    logic [31:0] d, wd;
    logic ovf, inx;
    int lat, wl;
    for (int i = 0; i < NV; i++) begin
      run(XV[i], i % 3, d, ovf, inx, lat);
`ifdef ROUND_NEAREST_EN
      wd = DR[i]; wl = LR[i];
`else
      wd = DT[i]; wl = LT[i];
`endif
      total++; if (d !== wd) begin bad++; $display("FAIL dir_data x=%h got=%h want=%h", XV[i], d, wd); end
      total++; if ({ovf, inx} !== FV[i]) begin bad++; $display("FAIL dir_flags x=%h got=%b want=%b", XV[i], {ovf, inx}, FV[i]); end
      total++; if (lat !== wl) begin bad++; $display("FAIL dir_latency x=%h got=%0d want=%0d", XV[i], lat, wl); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, d, wd;
    logic ovf, inx, wo, wi;
    int lat;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      if (i % 2 == 0) x[30:23] = 8'($urandom_range(118, 162));
      run(x, $urandom_range(0, 3), d, ovf, inx, lat);
      ref_model(x, wd, wo, wi);
      total++;
      if (lat < 0 || d !== wd || ovf !== wo || inx !== wi) begin
        bad++;
        $display("FAIL rand x=%h got=%h/%b/%b want=%h/%b/%b lat=%0d", x, d, ovf, inx, wd, wo, wi, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_data = 32'hC2F6_E979;
    @(posedge clk); #1 in_data = 32'h3F80_0000;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FF85 || {out_ovf, out_inexact} !== 2'b01 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold got=%b/%h/%b/%b want=1/ffffff85/01/0", out_valid, out_data, {out_ovf, out_inexact}, in_ready);
      end
    end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b want=01", {out_valid, in_ready}); end
    @(posedge clk); #1 in_valid = 0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", in_ready); end
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (out_data !== 32'd1 || n !== 9) begin bad++; $display("FAIL bp_next got=%h lat=%0d want=1 lat=9", out_data, n); end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, wd;
    logic ovf, inx, wo, wi;
    int lat;
    @(negedge clk);
    in_valid = 1; in_data = 32'h3F80_0000;
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1;
    total++; if ({out_valid, in_ready} !== 2'b00) begin bad++; $display("FAIL mid_reset got=%b want=00", {out_valid, in_ready}); end
    @(negedge clk) rst_n = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release got=%b want=1", in_ready); end
    repeat (12) @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_discard got=%b want=0", out_valid); end
    run(32'h4020_0000, 0, d, ovf, inx, lat);
    ref_model(32'h4020_0000, wd, wo, wi);
    total++; if (d !== wd || {ovf, inx} !== {wo, wi} || lat !== 9) begin bad++; $display("FAIL mid_next got=%h/%b/%b lat=%0d want=%h/%b/%b lat=9", d, ovf, inx, lat, wd, wo, wi); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
